if_fetch: RTL and testbench

//  Instruction-fetch stage directly upstream of inst_ram. Owns the PC, drives the SRAM

---
 rtl/if_fetch.sv | 166 ++++++++++++++++
 tb/tb_if_fetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch : instruction-fetch stage in front of inst_ram (1-cycle read latency)
//
// Owns the program counter, drives the SRAM read port and pairs the returning
// read data with the PC it was fetched from. The pair {if_pc, if_instr} is
// offered to decode over a valid/ready handshake.
//
// Handshake: an instruction transfers on a cycle where if_valid and if_ready
// are both 1. Once if_valid is raised, if_pc/if_instr stay stable until that
// transfer happens. The one exception is a redirect, which withdraws the
// presented instruction in the same cycle it arrives.
//
// Stall behaviour: while an instruction is held, the SRAM re-reads the same
// word so that its dout (which is not registered here) keeps showing it.
//
// Optional feature macro: FETCH_MISALIGN_EN
//   When defined, a redirect whose target is not word-aligned sets a sticky
//   misalign flag. The aligned target word is fetched and presented with
//   if_misalign=1, and fetching then stops until the next redirect.
//   When undefined, redirect_pc[1:0] is ignored and if_misalign is 0.
// ----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_csb,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic              if_misalign
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] pc_q,     pc_d;      // next sequential fetch address
  logic        rsp_v_q,  rsp_v_d;   // SRAM dout holds a live fetch
  logic [31:0] rsp_pc_q, rsp_pc_d;  // PC belonging to that fetch

  // Decoded control (combinational)
  logic [31:0] redir_tgt;           // redirect target, word-aligned
  logic        redir_mis;           // redirect target had low bits set
  logic [31:0] fetch_pc;            // address used if a new fetch issues
  logic        issue_blocked;       // misalign lock-out of sequential fetch
  logic        issue;               // a new fetch goes to the SRAM this cycle
  logic        csb_c;               // chip select before reset gating
  logic [31:0] rd_pc;               // address actually driven to the SRAM

`ifdef FETCH_MISALIGN_EN
  logic        misalign_q, misalign_d;

  // Sticky misalign flag: set by a misaligned redirect, cleared by any
  // aligned redirect, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  // The flag follows every accepted redirect, whether or not it fetches.
  always_comb begin
    misalign_d = misalign_q;
    if (rst_n && redirect_valid) begin
      misalign_d = redir_mis;
    end
  end

  // Misalign decode and lock-out of sequential fetch.
  always_comb begin
    redir_mis     = |redirect_pc[1:0];
    issue_blocked = misalign_q;
  end

  assign if_misalign = if_valid & misalign_q;
`else
  // Low target bits are deliberately dropped in this build.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // No misalign tracking: never blocks, never flags.
  always_comb begin
    redir_mis     = 1'b0;
    issue_blocked = 1'b0;
  end

  assign if_misalign = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Fetch state registers
  // --------------------------------------------------------------------------
  // Reset discards anything in flight and restarts at RESET_PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rsp_v_q  <= 1'b0;
      rsp_pc_q <= RESET_PC;
    end else begin
      pc_q     <= pc_d;
      rsp_v_q  <= rsp_v_d;
      rsp_pc_q <= rsp_pc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and SRAM port control, in priority order:
  //   issue > redirect without issue > hold (re-read) > drain/idle
  // --------------------------------------------------------------------------
  // A redirect always bypasses the lock-out so it can clear the misalign flag;
  // otherwise a new fetch needs a free slot: nothing held, or the held
  // instruction leaving this cycle.
  always_comb begin
    redir_tgt = {redirect_pc[31:2], 2'b00};
    fetch_pc  = redirect_valid ? redir_tgt : pc_q;
    issue     = rst_n & fetch_en &
                (redirect_valid | (~issue_blocked & (~rsp_v_q | if_ready)));

    pc_d      = pc_q;
    rsp_v_d   = rsp_v_q;
    rsp_pc_d  = rsp_pc_q;
    csb_c     = 1'b1;
    rd_pc     = fetch_pc;

    if (issue) begin
      // New fetch; wraps mod 2^32 at the top of the address space.
      csb_c    = 1'b0;
      rd_pc    = fetch_pc;
      rsp_v_d  = 1'b1;
      rsp_pc_d = fetch_pc;
      pc_d     = fetch_pc + 32'd4;
    end else if (redirect_valid) begin
      // Redirect while not allowed to fetch: drop the held word, park the
      // target in pc_q for when fetch_en returns.
      rsp_v_d  = 1'b0;
      pc_d     = redir_tgt;
    end else if (rsp_v_q && !if_ready) begin
      // Stall: re-read the held word so dout keeps presenting it.
      csb_c    = 1'b0;
      rd_pc    = rsp_pc_q;
    end else if (rsp_v_q && if_ready) begin
      // Last instruction consumed and nothing new issued.
      rsp_v_d  = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The SRAM is word addressed; bits above the array size alias.
  assign imem_addr = rd_pc[ADDR_W+1:2];
  assign imem_csb  = csb_c | ~rst_n;
  assign if_valid  = rst_n & rsp_v_q & ~redirect_valid;
  assign if_pc     = rsp_pc_q;
  assign if_instr  = imem_rdata;

endmodule

// File: tb/tb_if_fetch.sv
// ----------------------------------------------------------------------------
// tb_if_fetch : self-checking bench for if_fetch with a 512x32 SRAM model.
// Expected {misalign, pc} pairs go into exp_q as each scenario is driven; every
// accepted instruction pops one entry and is compared, with the expected
// instruction taken from the bench's own SRAM image.
// ----------------------------------------------------------------------------
module tb_if_fetch;

  localparam int ADDR_W = 9;
`ifdef FETCH_MISALIGN_EN
  localparam logic EXP_MIS = 1'b1;
`else
  localparam logic EXP_MIS = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              fetch_en;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              imem_csb;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_pc;
  logic [31:0]       if_instr;
  logic              if_misalign;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [32:0] exp_q [$];
  int          n_checks;
  int          n_pass;

  if_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_csb       (imem_csb),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_misalign    (if_misalign)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM model: 1-cycle read latency ----------------
  initial imem_rdata = 32'h0;
  always @(posedge clk) begin
    if (!imem_csb) imem_rdata <= mem[imem_addr];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic push(input logic mis, input logic [31:0] pc);
    exp_q.push_back({mis, pc});
  endtask

  // Let combinational outputs settle, then score any handshake this cycle.
  task automatic settle();
    logic [32:0] e;
    logic [31:0] epc;
    #1;
    if (if_valid === 1'b1 && if_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_accept_pc", if_pc, 32'hFFFF_FFFF);
      end else begin
        e   = exp_q.pop_front();
        epc = e[31:0];
        check("acc_pc", if_pc, epc);
        check("acc_instr", if_instr, mem[epc[ADDR_W+1:2]]);
        check("acc_misalign", {31'b0, if_misalign}, {31'b0, e[32]});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;

    rst_n = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Reset held 3 cycles: SRAM deselected, nothing presented.
    for (int i = 0; i < 3; i++) begin
      settle();
      check("rst_csb", {31'b0, imem_csb}, 32'd1);
      check("rst_valid", {31'b0, if_valid}, 32'd0);
      tick();
    end

    // 1: sequential stream from RESET_PC.
    rst_n = 1'b1;
    push(1'b0, 32'h0); push(1'b0, 32'h4); push(1'b0, 32'h8); push(1'b0, 32'hC);
    settle();
    check("first_addr", {23'b0, imem_addr}, 32'd0);
    check("first_csb", {31'b0, imem_csb}, 32'd0);
    check("first_valid", {31'b0, if_valid}, 32'd0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      settle();
      check("seq_valid", {31'b0, if_valid}, 32'd1);
      check("seq_addr", {23'b0, imem_addr}, i);
      tick();
    end

    // 2: stall on 0x10 for 4 cycles, then release without a bubble.
    if_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("stall_valid", {31'b0, if_valid}, 32'd1);
      check("stall_pc", if_pc, 32'h10);
      check("stall_instr", if_instr, mem[4]);
      check("stall_addr", {23'b0, imem_addr}, 32'd4);
      check("stall_csb", {31'b0, imem_csb}, 32'd0);
      tick();
    end
    if_ready = 1'b1;
    push(1'b0, 32'h10); push(1'b0, 32'h14); push(1'b0, 32'h18); push(1'b0, 32'h1C);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("release_valid", {31'b0, if_valid}, 32'd1);
      tick();
    end

    // 3: redirect during a stall on 0x20; 0x20 is dropped.
    if_ready = 1'b0;
    settle();
    check("hold20_pc", if_pc, 32'h20);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    settle();
    check("redir_kill_valid", {31'b0, if_valid}, 32'd0);
    check("redir_addr", {23'b0, imem_addr}, 32'h40);
    tick();
    redirect_valid = 1'b0; if_ready = 1'b1;
    push(1'b0, 32'h100); push(1'b0, 32'h104);
    cyc();
    cyc();

    // 4: wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    push(1'b0, 32'hFFFF_FFFC); push(1'b0, 32'h0); push(1'b0, 32'h4);
    settle();
    check("wrap_addr_hi", {23'b0, imem_addr}, 32'h1FF);
    tick();
    redirect_valid = 1'b0;
    settle();
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_addr_lo", {23'b0, imem_addr}, 32'h0);
    tick();
    cyc();

    // 5: fetch_en drops while 0x4 is presented and stalled.
    fetch_en = 1'b0; if_ready = 1'b0;
    settle();
    check("fe0_hold_valid", {31'b0, if_valid}, 32'd1);
    check("fe0_hold_csb", {31'b0, imem_csb}, 32'd0);
    check("fe0_hold_addr", {23'b0, imem_addr}, 32'd1);
    tick();
    if_ready = 1'b1;
    settle();
    check("fe0_drain_csb", {31'b0, imem_csb}, 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      settle();
      check("fe0_idle_valid", {31'b0, if_valid}, 32'd0);
      check("fe0_idle_csb", {31'b0, imem_csb}, 32'd1);
      tick();
    end
    fetch_en = 1'b1;
    push(1'b0, 32'h8); push(1'b0, 32'hC);
    settle();
    check("resume_addr", {23'b0, imem_addr}, 32'd2);
    tick();
    cyc();
    cyc();

    // 6: misaligned redirect to 0x102, then redirect to 0x200.
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    push(EXP_MIS, 32'h100);
    cyc();
    redirect_valid = 1'b0;
    cyc();
`ifdef FETCH_MISALIGN_EN
    settle();
    check("mis_block_valid", {31'b0, if_valid}, 32'd0);
    check("mis_block_csb", {31'b0, imem_csb}, 32'd1);
    tick();
`else
    push(1'b0, 32'h104);
    cyc();
`endif
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    push(1'b0, 32'h200);
    cyc();
    redirect_valid = 1'b0;
    cyc();

    // Reset mid-stream: in-flight work discarded, restart at 0.
    rst_n = 1'b0;
    settle();
    check("midrst_valid", {31'b0, if_valid}, 32'd0);
    check("midrst_csb", {31'b0, imem_csb}, 32'd1);
    tick();
    rst_n = 1'b1;
    settle();
    check("midrst_rel_valid", {31'b0, if_valid}, 32'd0);
    tick();

    // Random back-pressure over a long sequential run.
    for (int i = 0; i <= 64; i++) push(1'b0, 32'(i * 4));
    n = 0;
    while (exp_q.size() > 0 && n < 600) begin
      if_ready = 1'($urandom_range(0, 1));
      cyc();
      n++;
    end
    if_ready = 1'b0; fetch_en = 1'b0;
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
